// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM states and requester ids
// for the CPU bus arbiter.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    DONE
  } state_e;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0] is inst, req[1] is data.
// The last-grant register only moves when a grant is taken.
module rr_arb2
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       valid,
  output req_id_e    gnt
);

  req_id_e last;

  // pick the requester that did not win last time on a tie
  always_comb begin
    valid = |req;
    gnt   = REQ_INST;
    if (&req)
      gnt = (last == REQ_INST) ? REQ_DATA : REQ_INST;
    else if (req[1])
      gnt = REQ_DATA;
  end

  // remember who won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= REQ_INST;
    else if (en && valid)
      last <= gnt;
  end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one single-beat AXI master port between the
// instruction-fetch and load/store requesters.
module axi_bus_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  output logic              inst_err,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W/8-1:0] data_be,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  state_e  state;
  state_e  state_nx;
  req_id_e owner;
  req_id_e arb_gnt;
  logic    arb_valid;
  logic    arb_en;
  logic    sel_we;
  logic    we_q;
  logic    aw_ok;
  logic    w_ok;
  logic    rlast_unused;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;

  assign rlast_unused = rlast;

  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awsize  = AXI_SIZE_4B;
  assign arsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign awprot  = 3'd0;
  assign arprot  = 3'd0;
  assign wlast   = 1'b1;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = be_q;

  assign arb_en = (state == IDLE);
  assign sel_we = (arb_gnt == REQ_DATA) && data_we;

  rr_arb2 u_arb (
    .clk   (aclk),
    .rst_n (areset),
    .req   ({data_req, inst_req}),
    .en    (arb_en),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

  // state register
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    inst_done = 1'b0;
    data_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid)
          state_nx = sel_we ? WR_ADDR_DATA : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready)
          state_nx = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid)
          state_nx = DONE;
      end
      WR_ADDR_DATA: begin
        awvalid = !aw_ok;
        wvalid  = !w_ok;
        if ((aw_ok || awready) && (w_ok || wready))
          state_nx = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid)
          state_nx = DONE;
      end
      DONE: begin
        inst_done = (owner == REQ_INST);
        data_done = (owner == REQ_DATA);
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // latch the winner's payload at grant time
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      owner   <= REQ_INST;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (arb_en && arb_valid) begin
      owner <= arb_gnt;
      we_q  <= sel_we;
      if (arb_gnt == REQ_DATA) begin
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
        be_q    <= data_be;
      end else begin
        addr_q  <= inst_addr;
        wdata_q <= '0;
        be_q    <= '0;
      end
    end
  end

  // track which write channels have already handshaken
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
    end else if (state == WR_ADDR_DATA) begin
      if (awvalid && awready)
        aw_ok <= 1'b1;
      if (wvalid && wready)
        w_ok <= 1'b1;
    end else begin
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
    end
  end

  // capture response so it is valid with the done pulse
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      inst_rdata <= '0;
      inst_err   <= 1'b0;
      data_rdata <= '0;
      data_err   <= 1'b0;
    end else if (state == RD_DATA && rvalid && !we_q) begin
      if (owner == REQ_INST) begin
        inst_rdata <= rdata;
        inst_err   <= (rresp != AXI_RESP_OKAY);
      end else begin
        data_rdata <= rdata;
        data_err   <= (rresp != AXI_RESP_OKAY);
      end
    end else if (state == WR_RESP && bvalid) begin
      data_err <= (bresp != AXI_RESP_OKAY);
    end
  end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Self-checking bench for axi_bus_arbiter with a
// delay-programmable single-beat AXI slave model.
module tb_axi_bus_arbiter;

  logic        clk;
  logic        areset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        inst_err;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_err;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  axi_bus_arbiter dut (
    .aclk(clk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_done(inst_done),
    .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_rdata(data_rdata),
    .data_done(data_done), .data_err(data_err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int s_ar_d, s_r_d, s_aw_d, s_w_d, s_b_d;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic rd_pend, aw_got, w_got;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign arready = arvalid && (ar_cnt >= s_ar_d);
  assign awready = awvalid && (aw_cnt >= s_aw_d);
  assign wready  = wvalid && (w_cnt >= s_w_d);
  assign rvalid  = rd_pend && (r_cnt >= s_r_d);
  assign bvalid  = aw_got && w_got && (b_cnt >= s_b_d);
  assign rdata   = s_rdata;
  assign rresp   = s_resp;
  assign bresp   = s_resp;
  assign rlast   = 1'b1;

  always @(posedge clk or negedge areset) begin
    if (!areset) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0;
      w_cnt <= 0; b_cnt <= 0;
      rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_cnt <= 0; rd_pend <= 1'b1; r_cnt <= 0;
        s_araddr <= araddr;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rd_pend && !(arvalid && arready)) begin
        if (rvalid && rready) rd_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; s_awaddr <= awaddr;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_cnt <= 0; w_got <= 1'b1;
        s_wdata <= wdata; s_wstrb <= wstrb;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got) begin
        if (bvalid && bready) begin
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic p_ok, p_ar, p_arr, p_aw, p_awr, p_w, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;

  // scoreboard and valid-stability monitor
  always @(negedge clk) begin
    exp_t e;
    if (areset) begin
      if (inst_done || data_done) begin
        chk("done_exclusive", 32'(inst_done & data_done), 32'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got inst=%0b data=%0b expected none",
                   inst_done, data_done);
        end else begin
          e = sb.pop_front();
          chk("done_port", 32'(data_done), 32'(e.port));
          if (e.port) begin
            chk("data_err", 32'(data_err), 32'(e.err));
            if (e.chk_data) chk("data_rdata", data_rdata, e.data);
          end else begin
            chk("inst_err", 32'(inst_err), 32'(e.err));
            if (e.chk_data) chk("inst_rdata", inst_rdata, e.data);
          end
        end
      end
      if (p_ok && p_ar && !p_arr) begin
        chk("arvalid_hold", 32'(arvalid), 32'd1);
        chk("araddr_hold", araddr, p_araddr);
      end
      if (p_ok && p_aw && !p_awr) begin
        chk("awvalid_hold", 32'(awvalid), 32'd1);
        chk("awaddr_hold", awaddr, p_awaddr);
      end
      if (p_ok && p_w && !p_wr) begin
        chk("wvalid_hold", 32'(wvalid), 32'd1);
        chk("wdata_hold", wdata, p_wdata);
      end
    end
    p_ok = areset;
    p_ar = arvalid; p_arr = arready; p_araddr = araddr;
    p_aw = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_w = wvalid; p_wr = wready; p_wdata = wdata;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic do_txn(input vec_t v);
    exp_t e;
    int k, ar_k;
    logic got, w_first, zw;
    @(posedge clk); #1;
    s_ar_d = v.ar_d; s_r_d = v.r_d; s_aw_d = v.aw_d;
    s_w_d = v.w_d; s_b_d = v.b_d;
    s_rdata = v.rdat; s_resp = v.resp;
    e.port = v.is_data; e.chk_data = !v.we;
    e.data = v.rdat; e.err = v.exp_err;
    sb.push_back(e);
    if (v.is_data) begin
      data_req = 1'b1; data_we = v.we; data_addr = v.addr;
      data_wdata = v.wdat; data_be = v.be;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    k = 0; ar_k = 0; got = 1'b0; w_first = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (arvalid && ar_k == 0) ar_k = k;
      if (awvalid && !wvalid) w_first = 1'b0;
      if (!awvalid && wvalid) w_first = 1'b0;
      if (awvalid && !wvalid && k > 1) w_first = 1'b1;
      if (v.ar_d > 0 && arvalid) begin
        chk("stall_araddr", araddr, v.addr);
        chk("stall_nodone", 32'(inst_done | data_done), 32'd0);
      end
      got = inst_done | data_done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no done expected done within 200");
    end
    inst_req = 1'b0; data_req = 1'b0;
    zw = (v.ar_d + v.r_d + v.aw_d + v.w_d + v.b_d) == 0;
    if (zw) chk("done_latency", k, 4);
    if (zw && !v.we) chk("arvalid_latency", ar_k, 2);
    if (!v.we) begin
      chk("slave_araddr", s_araddr, v.addr);
    end else begin
      chk("slave_awaddr", s_awaddr, v.addr);
      chk("slave_wdata", s_wdata, v.wdat);
      chk("slave_wstrb", 32'(s_wstrb), 32'(v.be));
    end
    if (v.we && v.aw_d > v.w_d) chk("w_drops_first", 32'(w_first), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, nd;
    tbl[0] = '{1'b0, 1'b0, 32'h1FC00000, 32'h0, 4'h0,
               32'h3C1D8000, 2'b00, 0, 0, 0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 4'b0011,
               32'h0, 2'b00, 0, 0, 2, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h80002000, 32'h0, 4'h0,
               32'h12345678, 2'b10, 0, 0, 0, 0, 0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h80002004, 32'h0, 4'h0,
               32'h9ABCDEF0, 2'b00, 0, 3, 0, 0, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h80003000, 32'h01020304, 4'b1111,
               32'h0, 2'b00, 0, 0, 0, 3, 2, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h80003004, 32'hCAFEF00D, 4'b1100,
               32'h0, 2'b11, 0, 0, 0, 0, 0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h1FC00040, 32'h0, 4'h0,
               32'h00000013, 2'b00, 10, 0, 0, 0, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h80004000, 32'h55AA55AA, 4'b0101,
               32'h0, 2'b00, 0, 0, 1, 1, 0, 1'b0};

    areset = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0;
    data_wdata = '0; data_be = '0;
    s_ar_d = 0; s_r_d = 0; s_aw_d = 0; s_w_d = 0; s_b_d = 0;
    s_rdata = '0; s_resp = '0;

    @(negedge clk);
    chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    chk("rst_done", 32'({inst_done, data_done, inst_err, data_err}), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("const_ax", 32'({awlen, awsize, awburst, awprot, wlast}),
        32'({8'd0, 3'b010, 2'b01, 3'd0, 1'b1}));
    chk("const_ar", 32'({arlen, arsize, arburst, arprot}),
        32'({8'd0, 3'b010, 2'b01, 3'd0}));
    @(negedge clk);
    areset = 1'b1;

    for (int i = 0; i < 8; i++) do_txn(tbl[i]);

    // tie arbitration right after reset: data, inst, data, inst
    @(negedge clk); areset = 1'b0;
    @(negedge clk); areset = 1'b1;
    @(posedge clk); #1;
    s_ar_d = 0; s_r_d = 0; s_rdata = 32'h0BADCAFE; s_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.port = (i % 2 == 0); e.chk_data = 1'b1;
      e.data = 32'h0BADCAFE; e.err = 1'b0;
      sb.push_back(e);
    end
    inst_addr = 32'h00001000; data_addr = 32'h00002000;
    data_we = 1'b0;
    inst_req = 1'b1; data_req = 1'b1;
    n = 0; nd = 0;
    while (nd < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (inst_done || data_done) nd++;
    end
    inst_req = 1'b0; data_req = 1'b0;
    chk("rr_done_count", nd, 4);
    repeat (2) @(negedge clk);

    // reset while waiting for read data
    @(posedge clk); #1;
    s_r_d = 20; s_rdata = 32'h77777777;
    inst_addr = 32'h1FC00100; inst_req = 1'b1;
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_data", 32'(rready), 32'd1);
    areset = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk("rst_mid_rready", 32'(rready), 32'd0);
    chk("rst_mid_done", 32'(inst_done | data_done), 32'd0);
    inst_req = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b1;
    tbl[0].rdat = 32'h24080001;
    do_txn(tbl[0]);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
